// File: rtl/scurve_test_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scurve_test_sequencer_pkg
// Brief    : Shared state encoding, header tag and default sizes for the
//            S-curve test sequencer (optional header feature: SCURVE_HEADER_EN).
// Revision : 1.0 - initial release
// ============================================================================
package scurve_test_sequencer_pkg;

    localparam int c_CHN_NUM_DEF = 64;
    localparam int c_DAC_W_DEF   = 10;

    localparam logic [7:0] c_HDR_TAG = 8'hA5;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CFG       = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_CFG_WAIT  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_HEADER    = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_TEST      = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_TEST_WAIT = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_NEXT      = 3'd6;
    localparam logic [c_STATE_W-1:0] c_ST_DONE      = 3'd7;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_CFG       = c_ST_CFG,
        ST_CFG_WAIT  = c_ST_CFG_WAIT,
        ST_HEADER    = c_ST_HEADER,
        ST_TEST      = c_ST_TEST,
        ST_TEST_WAIT = c_ST_TEST_WAIT,
        ST_NEXT      = c_ST_NEXT,
        ST_DONE      = c_ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scurve_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : scurve_edge_detect
// Brief    : Registered rising-edge detector; rise is high while sig_in is 1
//            and its previous-cycle sample was 0.
// Revision : 1.0 - initial release
// ============================================================================
module scurve_edge_detect (
    input  logic Clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= sig_in;
        end
    end

    assign rise = sig_in & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/scurve_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scurve_test_sequencer
// Brief    : Sweeps threshold DAC codes (outer loop) and channels (inner loop),
//            configuring slow control and launching one S-curve test per point.
//            Optional header words to the data FIFO: define SCURVE_HEADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scurve_test_sequencer
    import scurve_test_sequencer_pkg::*;
#(
    parameter int CHN_NUM = c_CHN_NUM_DEF,
    parameter int DAC_W   = c_DAC_W_DEF
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             Test_Start,
    input  logic             Test_Stop,
    input  logic             Single_Chn_Mode,
    input  logic [5:0]       Single_Chn,
    input  logic [DAC_W-1:0] DAC_Start,
    input  logic [DAC_W-1:0] DAC_Stop,
    input  logic [DAC_W-1:0] DAC_Step,
    output logic             Cfg_Req,
    output logic [5:0]       Cfg_Chn,
    output logic [DAC_W-1:0] Cfg_DAC,
    input  logic             Cfg_Done,
    output logic             Chn_Test_Start,
    input  logic             One_Channel_Done,
    output logic [15:0]      Header_Data,
    output logic             Header_wr_en,
    output logic             Busy,
    output logic             All_Done
);

    localparam logic [5:0] c_LAST_CHN = 6'(CHN_NUM - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_chn;
    logic [5:0]       w_chn_nxt;
    logic [DAC_W-1:0] r_dac;
    logic [DAC_W-1:0] w_dac_nxt;
    logic             r_single;
    logic [5:0]       r_single_chn;
    logic [DAC_W-1:0] r_dac_stop;
    logic [DAC_W-1:0] r_dac_step;
    logic [DAC_W-1:0] w_step_eff;
    logic [DAC_W:0]   w_dac_sum;
    logic             w_launch;
    logic             w_start_rise;
    logic             w_done_rise;

    scurve_edge_detect u_start_edge (
        .Clk     (Clk),
        .reset_n (reset_n),
        .sig_in  (Test_Start),
        .rise    (w_start_rise)
    );

    // Tracks One_Channel_Done every cycle, so a level already high when TEST
    // is entered never looks like a fresh completion.
    scurve_edge_detect u_done_edge (
        .Clk     (Clk),
        .reset_n (reset_n),
        .sig_in  (One_Channel_Done),
        .rise    (w_done_rise)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_chn        <= '0;
            r_dac        <= '0;
            r_single     <= 1'b0;
            r_single_chn <= '0;
            r_dac_stop   <= '0;
            r_dac_step   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_chn   <= w_chn_nxt;
            r_dac   <= w_dac_nxt;
            if (w_launch) begin
                r_single     <= Single_Chn_Mode;
                r_single_chn <= Single_Chn;
                r_dac_stop   <= DAC_Stop;
                r_dac_step   <= DAC_Step;
            end
        end
    end

`ifdef SCURVE_HEADER_EN
    logic r_hdr_idx;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr_idx <= 1'b0;
        end else if (r_state == ST_HEADER && !Test_Stop) begin
            r_hdr_idx <= ~r_hdr_idx;
        end else begin
            r_hdr_idx <= 1'b0;
        end
    end
`endif

    // One extra bit on the sum keeps codes near full scale from wrapping low.
    assign w_step_eff = (r_dac_step == '0) ? DAC_W'(1) : r_dac_step;
    assign w_dac_sum  = {1'b0, r_dac} + {1'b0, w_step_eff};

    always_comb begin
        w_state_nxt = r_state;
        w_chn_nxt   = r_chn;
        w_dac_nxt   = r_dac;
        w_launch    = 1'b0;

        if (r_state != ST_IDLE && Test_Stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        w_launch    = 1'b1;
                        w_dac_nxt   = DAC_Start;
                        w_chn_nxt   = Single_Chn_Mode ? Single_Chn : 6'd0;
                        w_state_nxt = (DAC_Start > DAC_Stop) ? ST_DONE : ST_CFG;
                    end
                end
                ST_CFG: begin
                    w_state_nxt = ST_CFG_WAIT;
                end
                ST_CFG_WAIT: begin
                    if (Cfg_Done) begin
`ifdef SCURVE_HEADER_EN
                        w_state_nxt = ST_HEADER;
`else
                        w_state_nxt = ST_TEST;
`endif
                    end
                end
`ifdef SCURVE_HEADER_EN
                ST_HEADER: begin
                    if (r_hdr_idx) begin
                        w_state_nxt = ST_TEST;
                    end
                end
`endif
                ST_TEST: begin
                    w_state_nxt = ST_TEST_WAIT;
                end
                ST_TEST_WAIT: begin
                    if (w_done_rise) begin
                        w_state_nxt = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!r_single && r_chn < c_LAST_CHN) begin
                        w_chn_nxt   = r_chn + 6'd1;
                        w_state_nxt = ST_CFG;
                    end else begin
                        w_chn_nxt = r_single ? r_single_chn : 6'd0;
                        if (w_dac_sum > {1'b0, r_dac_stop}) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_dac_nxt   = w_dac_sum[DAC_W-1:0];
                            w_state_nxt = ST_CFG;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign Cfg_Req        = (r_state == ST_CFG) || (r_state == ST_CFG_WAIT);
    assign Chn_Test_Start = (r_state == ST_TEST) || (r_state == ST_TEST_WAIT);
    assign Busy           = (r_state != ST_IDLE);
    assign All_Done       = (r_state == ST_DONE);
    assign Cfg_Chn        = r_chn;
    assign Cfg_DAC        = r_dac;

`ifdef SCURVE_HEADER_EN
    assign Header_wr_en = (r_state == ST_HEADER);
    assign Header_Data  = !Header_wr_en ? 16'd0 :
                          r_hdr_idx     ? 16'(r_dac) :
                                          {c_HDR_TAG, 2'b00, r_chn};
`else
    assign Header_wr_en = 1'b0;
    assign Header_Data  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scurve_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scurve_test_sequencer
// Brief    : Self-checking bench: table vectors plus random sweeps, with
//            slow-control and counter-block responders (SCURVE_HEADER_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scurve_test_sequencer;

    localparam int c_CN = 4;
    localparam int c_DW = 10;

    logic            Clk;
    logic            reset_n;
    logic            Test_Start;
    logic            Test_Stop;
    logic            Single_Chn_Mode;
    logic [5:0]      Single_Chn;
    logic [c_DW-1:0] DAC_Start;
    logic [c_DW-1:0] DAC_Stop;
    logic [c_DW-1:0] DAC_Step;
    logic            Cfg_Req;
    logic [5:0]      Cfg_Chn;
    logic [c_DW-1:0] Cfg_DAC;
    logic            Cfg_Done;
    logic            Chn_Test_Start;
    logic            One_Channel_Done;
    logic [15:0]     Header_Data;
    logic            Header_wr_en;
    logic            Busy;
    logic            All_Done;

    scurve_test_sequencer #(.CHN_NUM(c_CN), .DAC_W(c_DW)) dut (
        .Clk              (Clk),
        .reset_n          (reset_n),
        .Test_Start       (Test_Start),
        .Test_Stop        (Test_Stop),
        .Single_Chn_Mode  (Single_Chn_Mode),
        .Single_Chn       (Single_Chn),
        .DAC_Start        (DAC_Start),
        .DAC_Stop         (DAC_Stop),
        .DAC_Step         (DAC_Step),
        .Cfg_Req          (Cfg_Req),
        .Cfg_Chn          (Cfg_Chn),
        .Cfg_DAC          (Cfg_DAC),
        .Cfg_Done         (Cfg_Done),
        .Chn_Test_Start   (Chn_Test_Start),
        .One_Channel_Done (One_Channel_Done),
        .Header_Data      (Header_Data),
        .Header_wr_en     (Header_wr_en),
        .Busy             (Busy),
        .All_Done         (All_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // abort_kind: 0 none, 1 Test_Stop (together with a done edge), 2 reset
    typedef struct {
        int mode;
        int chn;
        int dstart;
        int dstop;
        int dstep;
        int abort_kind;
        int abort_at;
        int ocd_hold;
        int exp_tests;
        int exp_done;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] exp_q[$];
        logic [15:0] cfg_q[$];
        logic [15:0] test_q[$];
        logic [15:0] hdr_q[$];
        int  exp_n, exp_d, n_done, hs_err, done_cycle, idle_cnt;
        int  cfg_wait, ocd_phase, ocd_cnt, n_tests, abort_kind;
        bit  prev_req, prev_ts, cfg_done_drv, abort_chk, rel_pending, timed_out;

        // Reference: DAC outer loop by plain arithmetic, channels inner
        exp_q = {};
        for (int d = v.dstart; d <= v.dstop; d += (v.dstep == 0 ? 1 : v.dstep)) begin
            if (v.mode != 0) exp_q.push_back({6'(v.chn), 10'(d)});
            else for (int c = 0; c < c_CN; c++) exp_q.push_back({6'(c), 10'(d)});
        end
        abort_kind = (v.abort_kind != 0 && v.abort_at >= 1 && v.abort_at <= exp_q.size()) ? v.abort_kind : 0;
        exp_n = (abort_kind != 0) ? v.abort_at : exp_q.size();
        exp_d = (abort_kind != 0) ? 0 : 1;
        if (v.exp_tests >= 0) exp_n = v.exp_tests;
        if (v.exp_done >= 0)  exp_d = v.exp_done;

        n_done = 0; hs_err = 0; done_cycle = -1; idle_cnt = 0;
        cfg_wait = 0; ocd_phase = 0; ocd_cnt = 0; n_tests = 0;
        prev_req = 0; prev_ts = 0; cfg_done_drv = 0; abort_chk = 0; rel_pending = 0; timed_out = 1;

        @(negedge Clk);
        Single_Chn_Mode = 1'(v.mode);
        Single_Chn      = 6'(v.chn);
        DAC_Start       = 10'(v.dstart);
        DAC_Stop        = 10'(v.dstop);
        DAC_Step        = 10'(v.dstep);
        Test_Start      = 1'b1;

        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge Clk);
            Test_Start = 1'b0;
            Cfg_Done   = 1'b0;
            Test_Stop  = 1'b0;
            if (abort_chk) begin
                check({tag, "_abort_busy"}, Busy, 1'b0);
                check({tag, "_abort_cts"}, Chn_Test_Start, 1'b0);
                abort_chk = 0;
            end
            if (rel_pending) begin
                reset_n = 1'b1;
                rel_pending = 0;
            end
            if (All_Done) begin
                n_done++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (Header_wr_en) hdr_q.push_back(Header_Data);
            if (cfg_done_drv && Cfg_Req) hs_err++;
            cfg_done_drv = 0;

            if (Cfg_Req && !prev_req) begin
                cfg_q.push_back({Cfg_Chn, Cfg_DAC});
                cfg_wait = $urandom_range(1, 3);
            end else if (Cfg_Req) begin
                if ({Cfg_Chn, Cfg_DAC} != cfg_q[$]) hs_err++;
                if (cfg_wait > 0) begin
                    cfg_wait--;
                    if (cfg_wait == 0) begin
                        Cfg_Done = 1'b1;
                        cfg_done_drv = 1;
                    end
                end
                // Start edges while busy must be ignored
                Test_Start = 1'($urandom_range(0, 1));
            end

            if (Chn_Test_Start && !prev_ts) begin
                test_q.push_back({Cfg_Chn, Cfg_DAC});
                n_tests++;
                ocd_phase = 1;
                ocd_cnt = (v.ocd_hold > 0) ? v.ocd_hold : $urandom_range(1, 3);
            end else if (ocd_phase == 1) begin
                if (!Chn_Test_Start) hs_err++;
                ocd_cnt--;
                if (ocd_cnt == 0) begin
                    One_Channel_Done = 1'b0;
                    ocd_phase = 2;
                    ocd_cnt = $urandom_range(1, 3);
                end
            end else if (ocd_phase == 2) begin
                if (!Chn_Test_Start) hs_err++;
                ocd_cnt--;
                if (ocd_cnt == 0) begin
                    One_Channel_Done = 1'b1;
                    ocd_phase = 3;
                    if (abort_kind == 1 && n_tests == v.abort_at) begin
                        Test_Stop = 1'b1;
                        abort_chk = 1;
                    end else if (abort_kind == 2 && n_tests == v.abort_at) begin
                        reset_n = 1'b0;
                        #1;
                        check({tag, "_rst_outs"},
                              {Busy, Cfg_Req, Chn_Test_Start, All_Done, Cfg_Chn, Cfg_DAC}, '0);
                        rel_pending = 1;
                    end
                end
            end else if (ocd_phase == 3) begin
                if (Chn_Test_Start) hs_err++;
                ocd_phase = 0;
            end

            prev_req = Cfg_Req;
            prev_ts  = Chn_Test_Start;
            idle_cnt = (Busy || rel_pending) ? 0 : idle_cnt + 1;
            if (idle_cnt >= 3) begin
                timed_out = 0;
                break;
            end
        end
        reset_n = 1'b1;
        Test_Start = 1'b0;

        check({tag, "_timeout"}, timed_out, 1'b0);
        check({tag, "_n_tests"}, test_q.size(), exp_n);
        check({tag, "_n_cfg"}, cfg_q.size(), exp_n);
        check({tag, "_all_done"}, n_done, exp_d);
        check({tag, "_handshake_err"}, hs_err, 0);
        for (int i = 0; i < exp_n && i < test_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_test%0d", tag, i), test_q[i], exp_q[i]);
            if (i < cfg_q.size()) check($sformatf("%s_cfg%0d", tag, i), cfg_q[i], exp_q[i]);
        end
        if (exp_q.size() == 0) check({tag, "_done_latency_ok"}, (done_cycle >= 1 && done_cycle <= 2), 1'b1);
`ifdef SCURVE_HEADER_EN
        check({tag, "_hdr_count"}, hdr_q.size(), 2 * exp_n);
        for (int i = 0; i < exp_n && 2 * i + 1 < hdr_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_hdr%0d_a", tag, i), hdr_q[2*i],   {8'hA5, 2'b00, exp_q[i][15:10]});
            check($sformatf("%s_hdr%0d_b", tag, i), hdr_q[2*i+1], {6'd0, exp_q[i][9:0]});
        end
`else
        check({tag, "_hdr_count"}, hdr_q.size(), 0);
`endif
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        reset_n = 1'b0;
        Test_Start = 1'b0; Test_Stop = 1'b0; Single_Chn_Mode = 1'b0; Single_Chn = '0;
        DAC_Start = '0; DAC_Stop = '0; DAC_Step = '0; Cfg_Done = 1'b0; One_Channel_Done = 1'b0;

        //           mode chn start stop step abort at hold exp_t done
        tbl.push_back('{1,  5,  100,  102, 1,   0, 0, 0,   3, 1});
        tbl.push_back('{0,  0,    0,    0, 1,   0, 0, 0,   4, 1});
        tbl.push_back('{1,  0, 1020, 1023, 5,   0, 0, 0,   1, 1});
        tbl.push_back('{0,  0,  200,  100, 1,   0, 0, 0,   0, 1});
        tbl.push_back('{1, 63,   10,   20, 0,   0, 0, 0,  11, 1});
        tbl.push_back('{0,  0,    5,    9, 2,   0, 0, 0,  12, 1});
        tbl.push_back('{0,  0,    0,    3, 4,   0, 0, 0,   4, 1});
        tbl.push_back('{0,  0,    0,    5, 1,   1, 2, 0,   2, 0});
        tbl.push_back('{1,  7, 1023, 1023, 1023, 0, 0, 0,  1, 1});
        tbl.push_back('{1,  9,  300,  301, 1,   2, 1, 0,   1, 0});
        tbl.push_back('{1,  2,   50,   51, 1,   0, 0, 0,   2, 1});
        tbl.push_back('{0,  0,   40,   40, 1,   0, 0, 8,   4, 1});

        #2;
        check("reset_outs", {Busy, Cfg_Req, Chn_Test_Start, All_Done, Header_wr_en}, 5'd0);
        check("reset_vals", {Cfg_Chn, Cfg_DAC, Header_Data}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
        check("idle_busy", Busy, 1'b0);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 25; r++) begin
            rv.mode   = int'($urandom_range(0, 1));
            rv.chn    = int'($urandom_range(0, 63));
            rv.dstart = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 5) == 0 && rv.dstart > 0)
                rv.dstop = int'($urandom_range(0, rv.dstart - 1));
            else
                rv.dstop = (rv.dstart + int'($urandom_range(0, 6)) > 1023) ? 1023 : rv.dstart + int'($urandom_range(0, 6));
            rv.dstep      = int'($urandom_range(0, 3));
            rv.abort_kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
            rv.abort_at   = int'($urandom_range(1, 4));
            rv.ocd_hold   = 0;
            rv.exp_tests  = -1;
            rv.exp_done   = -1;
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
